crc_serial_engine: RTL

Parametrised bit-serial CRC generator, the successor to the fixed CRC7 shift-register block. Polynomial, width and initial value are set by parameters. A start/last framing handshake replaces free-running accumulation. After the message, the computed CRC is emitted MSB-first on a ready/valid serial stream. The block sits between the serial command/frame builder and the output line driver.

---
 rtl/crc_serial_pkg.sv | 15 +
 rtl/crc_serial_step.sv | 18 +
 rtl/crc_serial_engine.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/crc_serial_pkg.sv
// rtl/crc_serial_pkg.sv - shared state encoding and standard polynomials for the serial CRC engine
package crc_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    EMIT,
    DONE,
    CHECK
  } state_t;

  localparam logic [6:0]  CRC7_SD_POLY     = 7'h09;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

endpackage

// File: rtl/crc_serial_step.sv
// rtl/crc_serial_step.sv - combinational one-bit MSB-first CRC update
module crc_serial_step
  import crc_serial_pkg::*;
#(
  parameter int                   CRC_WIDTH = 7,
  parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(CRC7_SD_POLY)
) (
  input  logic [CRC_WIDTH-1:0] crc,
  input  logic                 bit_in,
  output logic [CRC_WIDTH-1:0] crc_next
);

  logic fb;

  assign fb       = bit_in ^ crc[CRC_WIDTH-1];
  assign crc_next = {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_serial_engine.sv
// rtl/crc_serial_engine.sv - framed bit-serial CRC generator with MSB-first serial emit
// Optional receive-side check mode is compiled in with CRC_SERIAL_CHECK_EN.
module crc_serial_engine
  import crc_serial_pkg::*;
#(
  parameter int                   CRC_WIDTH = 7,
  parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(CRC7_SD_POLY),
  parameter logic [CRC_WIDTH-1:0] INIT      = '0,
  parameter int                   MAX_BITS  = 48,
  parameter int                   CNT_W     = $clog2(MAX_BITS + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 last,
  input  logic                 ser_ready,
`ifdef CRC_SERIAL_CHECK_EN
  input  logic                 check_mode,
  output logic                 crc_ok,
  output logic                 crc_chk_valid,
`endif
  output logic                 ser_out,
  output logic                 ser_valid,
  output logic [CRC_WIDTH-1:0] crc_out,
  output logic [CNT_W-1:0]     msg_bits,
  output logic                 busy,
  output logic                 crc_done,
  output logic                 len_err
);

  localparam int                EMIT_W   = $clog2(CRC_WIDTH + 1);
  localparam logic [EMIT_W-1:0] LAST_IDX = EMIT_W'(CRC_WIDTH - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_BITS);

  state_t               state, state_nxt;
  logic [CRC_WIDTH-1:0] crc, crc_nxt, crc_step;
  logic [CNT_W-1:0]     msg_nxt;
  logic [EMIT_W-1:0]    emit_cnt, emit_nxt;
  logic                 len_err_nxt;
  logic                 chk_mode, chk_mode_nxt;

  crc_serial_step #(
    .CRC_WIDTH (CRC_WIDTH),
    .POLY      (POLY)
  ) u_step (
    .crc      (crc),
    .bit_in   (bit_in),
    .crc_next (crc_step)
  );

  always_comb begin
    state_nxt    = state;
    crc_nxt      = crc;
    msg_nxt      = msg_bits;
    emit_nxt     = emit_cnt;
    len_err_nxt  = len_err;
    chk_mode_nxt = chk_mode;
    // start wins over everything, including a bit presented in the same cycle
    if (start) begin
      state_nxt   = ACCUM;
      crc_nxt     = INIT;
      msg_nxt     = '0;
      emit_nxt    = '0;
      len_err_nxt = 1'b0;
`ifdef CRC_SERIAL_CHECK_EN
      chk_mode_nxt = check_mode;
`else
      chk_mode_nxt = 1'b0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (bit_valid) begin
            crc_nxt = crc_step;
            if (msg_bits == MAX_CNT) begin
              if (!last) len_err_nxt = 1'b1;
            end else begin
              msg_nxt = msg_bits + 1'b1;
            end
            if (last) state_nxt = chk_mode ? CHECK : EMIT;
          end
        end
        EMIT: begin
          if (ser_ready) begin
            crc_nxt  = {crc[CRC_WIDTH-2:0], 1'b0};
            emit_nxt = emit_cnt + 1'b1;
            if (emit_cnt == LAST_IDX) begin
              emit_nxt  = '0;
              state_nxt = DONE;
            end
          end
        end
        CHECK: begin
          if (bit_valid) begin
            crc_nxt  = crc_step;
            emit_nxt = emit_cnt + 1'b1;
            if (emit_cnt == LAST_IDX) begin
              emit_nxt  = '0;
              state_nxt = DONE;
            end
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      crc      <= INIT;
      msg_bits <= '0;
      emit_cnt <= '0;
      len_err  <= 1'b0;
      chk_mode <= 1'b0;
    end else begin
      state    <= state_nxt;
      crc      <= crc_nxt;
      msg_bits <= msg_nxt;
      emit_cnt <= emit_nxt;
      len_err  <= len_err_nxt;
      chk_mode <= chk_mode_nxt;
    end
  end

  assign crc_out   = crc;
  assign ser_valid = (state == EMIT);
  assign ser_out   = (state == EMIT) && crc[CRC_WIDTH-1];
  assign busy      = (state == ACCUM) || (state == EMIT) || (state == CHECK);
  assign crc_done  = (state == DONE) && !chk_mode;

`ifdef CRC_SERIAL_CHECK_EN
  assign crc_chk_valid = (state == DONE) && chk_mode;
  assign crc_ok        = crc_chk_valid && (crc == '0);
`endif

endmodule
